// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation controller: default sizes,
// opcode assignments and the controller FSM state encoding.
package alu_pkg;

    localparam int ALU_WIDTH   = 4;
    localparam int ALU_NUM_OPS = 4;
    localparam int ALU_OPW     = 3;

    localparam int OP_AND = 0;
    localparam int OP_OR  = 1;
    localparam int OP_XOR = 2;
    localparam int OP_ADD = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;

endpackage

// File: rtl/alu_res_mux.sv
// Selects the enabled function unit's result slice and derives zero/error flags.
// An illegal opcode yields zero data so that undriven (X) slices never propagate.
module alu_res_mux #(
    parameter int WIDTH   = alu_pkg::ALU_WIDTH,
    parameter int NUM_OPS = alu_pkg::ALU_NUM_OPS,
    parameter int OPW     = alu_pkg::ALU_OPW
) (
    input  logic [OPW-1:0]           op,
    input  logic [NUM_OPS*WIDTH-1:0] fu_res,
    output logic [WIDTH-1:0]         data,
    output logic                     zero,
    output logic                     err
);

    always_comb begin
        data = '0;
        err  = 1'b1;
        for (int unsigned k = 0; k < NUM_OPS; k++) begin
            if (op == OPW'(k)) begin
                data = fu_res[k*WIDTH +: WIDTH];
                err  = 1'b0;
            end
        end
        zero = (data == '0);
    end

endmodule

// File: rtl/alu_op_ctrl.sv
// Upstream controller for the ALU function units: accepts an operation,
// pulses the selected unit's enable for one cycle, then holds its result.
module alu_op_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int NUM_OPS = ALU_NUM_OPS,
    parameter int OPW     = ALU_OPW
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPW-1:0]           in_op,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    output logic [NUM_OPS-1:0]       fu_en,
    output logic [WIDTH-1:0]         fu_a,
    output logic [WIDTH-1:0]         fu_b,
    input  logic [NUM_OPS*WIDTH-1:0] fu_res,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_zero,
    output logic                     out_err,
    output logic [7:0]               op_count
);

    alu_state_t         state, state_next;
    logic [OPW-1:0]     op_r;
    logic [WIDTH-1:0]   a_r, b_r;
    logic [WIDTH-1:0]   mux_data;
    logic               mux_zero, mux_err;
    logic               accept, consume;

    assign accept  = in_valid && in_ready;
    assign consume = (state == ST_DONE) && out_ready;

    alu_res_mux #(
        .WIDTH   (WIDTH),
        .NUM_OPS (NUM_OPS),
        .OPW     (OPW)
    ) u_res_mux (
        .op     (op_r),
        .fu_res (fu_res),
        .data   (mux_data),
        .zero   (mux_zero),
        .err    (mux_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (in_valid) state_next = ST_EXEC;
            ST_EXEC: state_next = ST_DONE;
            ST_DONE: if (out_ready) state_next = in_valid ? ST_EXEC : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Illegal opcodes match no index, so fu_en stays all-zero for them.
    always_comb begin
        fu_en     = '0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            ST_IDLE: in_ready = 1'b1;
            ST_EXEC: begin
                for (int unsigned k = 0; k < NUM_OPS; k++) begin
                    fu_en[k] = (op_r == OPW'(k));
                end
            end
            ST_DONE: begin
                in_ready  = out_ready;
                out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign fu_a = a_r;
    assign fu_b = b_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            op_r     <= '0;
            a_r      <= '0;
            b_r      <= '0;
            out_data <= '0;
            out_zero <= 1'b0;
            out_err  <= 1'b0;
            op_count <= '0;
        end else begin
            if (accept) begin
                op_r <= in_op;
                a_r  <= in_a;
                b_r  <= in_b;
            end
            if (state == ST_EXEC) begin
                out_data <= mux_data;
                out_zero <= mux_zero;
                out_err  <= mux_err;
            end
            if (consume) begin
                op_count <= op_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_op_ctrl.sv
// Directed self-checking bench for alu_op_ctrl with behavioural function
// units that drive X on any slice whose enable is low.
module tb_alu_op_ctrl;
    import alu_pkg::*;

    localparam int W  = 4;
    localparam int N  = 4;
    localparam int OW = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [OW-1:0]  in_op;
    logic [W-1:0]   in_a, in_b;
    logic [N-1:0]   fu_en;
    logic [W-1:0]   fu_a, fu_b;
    logic [N*W-1:0] fu_res;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic           out_zero;
    logic           out_err;
    logic [7:0]     op_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_op_ctrl #(.WIDTH(W), .NUM_OPS(N), .OPW(OW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .fu_en(fu_en), .fu_a(fu_a), .fu_b(fu_b), .fu_res(fu_res),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_zero(out_zero), .out_err(out_err),
        .op_count(op_count)
    );

    // Function units: disabled units drive X.
    always_comb begin
        fu_res = 'x;
        if (fu_en[OP_AND]) fu_res[OP_AND*W +: W] = fu_a & fu_b;
        if (fu_en[OP_OR])  fu_res[OP_OR*W  +: W] = fu_a | fu_b;
        if (fu_en[OP_XOR]) fu_res[OP_XOR*W +: W] = fu_a ^ fu_b;
        if (fu_en[OP_ADD]) fu_res[OP_ADD*W +: W] = fu_a + fu_b;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [OW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_op = '0; in_a = '0; in_b = '0;
        repeat (3) tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (fu_en !== 4'b0000) begin errors++; $display("FAIL reset_fu_en got %b want 0000", fu_en); end
        checks++; if ({fu_a, fu_b} !== 8'h00) begin errors++; $display("FAIL reset_fu_ab got %h want 00", {fu_a, fu_b}); end
        checks++; if ({out_data, out_zero, out_err} !== 6'b0) begin errors++; $display("FAIL reset_out got %b want 000000", {out_data, out_zero, out_err}); end
        checks++; if (op_count !== 8'd0) begin errors++; $display("FAIL reset_op_count got %0d want 0", op_count); end
        reset = 1'b0;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_and();
        out_ready = 1'b1;
        present(3'd0, 4'b1100, 4'b1010);
        tick();
        in_valid = 1'b0;
        checks++; if (fu_en !== 4'b0001) begin errors++; $display("FAIL and_fu_en got %b want 0001", fu_en); end
        checks++; if ({fu_a, fu_b} !== 8'hCA) begin errors++; $display("FAIL and_fu_ab got %h want ca", {fu_a, fu_b}); end
        checks++; if ({in_ready, out_valid} !== 2'b00) begin errors++; $display("FAIL and_exec_hs got %b want 00", {in_ready, out_valid}); end
        tick();
        checks++; if (fu_en !== 4'b0000) begin errors++; $display("FAIL and_fu_en_drop got %b want 0000", fu_en); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL and_out_valid got %b want 1", out_valid); end
        checks++; if ({out_data, out_zero, out_err} !== 6'b1000_0_0) begin errors++; $display("FAIL and_result got %b want 100000", {out_data, out_zero, out_err}); end
        tick();
        checks++; if (op_count !== 8'd1) begin errors++; $display("FAIL and_op_count got %0d want 1", op_count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL and_idle_valid got %b want 0", out_valid); end
    endtask

    task automatic test_xor();
        present(3'd2, 4'b0110, 4'b0110);
        tick();
        in_valid = 1'b0;
        checks++; if (fu_en !== 4'b0100) begin errors++; $display("FAIL xor_fu_en got %b want 0100", fu_en); end
        tick();
        checks++; if ({out_valid, out_data, out_zero, out_err} !== 7'b1_0000_1_0) begin errors++; $display("FAIL xor_result got %b want 1000010", {out_valid, out_data, out_zero, out_err}); end
        tick();
        checks++; if (op_count !== 8'd2) begin errors++; $display("FAIL xor_op_count got %0d want 2", op_count); end
    endtask

    task automatic test_illegal();
        present(3'd5, 4'b1111, 4'b0001);
        tick();
        in_valid = 1'b0;
        checks++; if (fu_en !== 4'b0000) begin errors++; $display("FAIL ill_fu_en_exec got %b want 0000", fu_en); end
        tick();
        checks++; if (fu_en !== 4'b0000) begin errors++; $display("FAIL ill_fu_en_done got %b want 0000", fu_en); end
        checks++; if ({out_valid, out_data, out_zero, out_err} !== 7'b1_0000_1_1) begin errors++; $display("FAIL ill_result got %b want 1000011", {out_valid, out_data, out_zero, out_err}); end
        tick();
        checks++; if (op_count !== 8'd3) begin errors++; $display("FAIL ill_op_count got %0d want 3", op_count); end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        out_ready = 1'b0;
        present(3'd3, 4'd7, 4'd5);
        tick();
        present(3'd1, 4'b0011, 4'b1000);
        tick();
        repeat (10) begin
            if (out_valid !== 1'b1 || out_data !== 4'hC || in_ready !== 1'b0 || fu_en !== 4'b0000) bad++;
            tick();
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold got %0d bad cycles want 0", bad); end
        checks++; if ({out_valid, out_data} !== 5'b1_1100) begin errors++; $display("FAIL bp_hold_end got %b want 11100", {out_valid, out_data}); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        in_a = 4'b0000;
        checks++; if ({fu_en, out_valid} !== 5'b0010_0) begin errors++; $display("FAIL bp_accept got %b want 00100", {fu_en, out_valid}); end
        checks++; if (op_count !== 8'd4) begin errors++; $display("FAIL bp_op_count got %0d want 4", op_count); end
        tick();
        checks++; if ({out_valid, out_data, out_err} !== 6'b1_1011_0) begin errors++; $display("FAIL bp_second got %b want 110110", {out_valid, out_data, out_err}); end
        tick();
        checks++; if (op_count !== 8'd5) begin errors++; $display("FAIL bp_op_count2 got %0d want 5", op_count); end
    endtask

    task automatic test_back_to_back();
        logic [OW-1:0] ops [3] = '{3'd0, 3'd1, 3'd3};
        logic [W-1:0]  as  [3] = '{4'b1111, 4'b0001, 4'b1001};
        logic [W-1:0]  bs  [3] = '{4'b0101, 4'b0010, 4'b1000};
        logic [W-1:0]  exp [3] = '{4'b0101, 4'b0011, 4'b0001};
        logic [N-1:0]  ens [3] = '{4'b0001, 4'b0010, 4'b1000};
        out_ready = 1'b1;
        present(ops[0], as[0], bs[0]);
        tick();
        for (int i = 0; i < 3; i++) begin
            if (i < 2) present(ops[i+1], as[i+1], bs[i+1]);
            else in_valid = 1'b0;
            checks++; if (fu_en !== ens[i]) begin errors++; $display("FAIL b2b_fu_en%0d got %b want %b", i, fu_en, ens[i]); end
            tick();
            checks++; if ({out_valid, out_data} !== {1'b1, exp[i]}) begin errors++; $display("FAIL b2b_res%0d got %b want %b", i, {out_valid, out_data}, {1'b1, exp[i]}); end
            tick();
        end
        checks++; if (op_count !== 8'd8) begin errors++; $display("FAIL b2b_op_count got %0d want 8", op_count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        present(3'd2, 4'b1010, 4'b0101);
        tick();
        in_valid = 1'b0;
        checks++; if (fu_en !== 4'b0100) begin errors++; $display("FAIL rst_exec_fu_en got %b want 0100", fu_en); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if ({fu_en, out_valid} !== 5'b0) begin errors++; $display("FAIL rst_exec_clear got %b want 00000", {fu_en, out_valid}); end
        checks++; if (op_count !== 8'd0) begin errors++; $display("FAIL rst_exec_count got %0d want 0", op_count); end
        repeat (4) begin
            if (out_valid !== 1'b0) seen++;
            tick();
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rst_discard got %0d valid cycles want 0", seen); end
        out_ready = 1'b0;
        present(3'd3, 4'd1, 4'd1);
        tick();
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if ({out_valid, out_data, op_count} !== 13'b0) begin errors++; $display("FAIL rst_done_clear got %b want 0", {out_valid, out_data, op_count}); end
    endtask

    task automatic test_count_wrap();
        out_ready = 1'b1;
        present(3'd0, 4'hF, 4'hF);
        tick();
        repeat (255) begin tick(); tick(); end
        checks++; if (op_count !== 8'd255) begin errors++; $display("FAIL wrap_255 got %0d want 255", op_count); end
        in_valid = 1'b0;
        tick();
        tick();
        checks++; if (op_count !== 8'd0) begin errors++; $display("FAIL wrap_0 got %0d want 0", op_count); end
    endtask

    initial begin
        test_reset();
        test_and();
        test_xor();
        test_illegal();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_count_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
